// File: rtl/axi_pkg.sv
// Shared AXI constants for the SRAM slave: response codes, burst/size codes,
// the slave FSM state encoding and a burst-length clamp helper.
// No ports (package).
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    localparam int         MAX_BEATS   = 4;

    // Slave FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_CAP   = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_DATA  = 3'd4;
    localparam logic [2:0] ST_WR_RESP  = 3'd5;

    // Bursts longer than MAX_BEATS are truncated to MAX_BEATS beats (and
    // flagged as errors by the caller).
    function automatic logic [1:0] clamp_len(input logic [7:0] len);
        return (len > 8'(MAX_BEATS - 1)) ? 2'(MAX_BEATS - 1) : len[1:0];
    endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of a single-port synchronous SRAM. Serves one
// transaction at a time: single beats or INCR bursts of up to 4 32-bit beats.
// Longer bursts are truncated to 4 beats and answered with SLVERR.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   ar*/arvalid/arready    read address channel (size/burst/lock/cache/prot ignored)
//   r*/rvalid/rready       read data channel
//   aw*/awvalid/awready    write address channel (size/burst/lock/cache/prot ignored)
//   w*/wvalid/wready       write data channel (wid ignored)
//   b*/bvalid/bready       write response channel
//   ram_en/we/addr/wdata   SRAM request; ram_rdata is valid the cycle after a read
//   dbg_state              current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Outputs driven with valid are held stable until that edge;
// ready outputs here are combinational from state and the incoming valids.
import axi_pkg::*;

module axi_sram_slave #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state;
    logic              prio;      // 1: write was granted last, 0: read was
    logic [3:0]        id_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        len_q;
    logic [1:0]        beat;
    logic              err;
    logic [31:0]       rdata_q;

    logic grant_w, grant_r, in_idle, beat_last, w_fire;

    // Ignored request attributes and unused address bits.
    logic unused_inputs;
    assign unused_inputs = ^{arsize, arburst, arlock, arcache, arprot, araddr[31:ADDR_W+2], araddr[1:0],
                             awsize, awburst, awlock, awcache, awprot, awaddr[31:ADDR_W+2], awaddr[1:0], wid};

    // Two-way round robin: with both requests pending, serve the class that
    // did not win last time.
    assign grant_w = awvalid & (~arvalid | ~prio);
    assign grant_r = arvalid & ~grant_w;

    // Every handshake/strobe output is gated by resetn so nothing leaks out
    // while reset is held, even before the synchronous reset has taken effect.
    assign in_idle   = resetn & (state == ST_IDLE);
    assign awready   = in_idle & grant_w;
    assign arready   = in_idle & grant_r;
    assign rvalid    = resetn & (state == ST_RD_DATA);
    assign wready    = resetn & (state == ST_WR_DATA);
    assign bvalid    = resetn & (state == ST_WR_RESP);

    assign beat_last = (beat == len_q);
    assign w_fire    = wready & wvalid;

    assign rid       = id_q;
    assign rdata     = rdata_q;
    assign rlast     = beat_last;
    assign rresp     = err ? RESP_SLVERR : RESP_OKAY;
    assign bid       = id_q;
    assign bresp     = err ? RESP_SLVERR : RESP_OKAY;
    assign dbg_state = state;

    // Address wraps silently within the SRAM.
    assign ram_addr  = base_q + ADDR_W'(beat);
    assign ram_wdata = wdata;

    // Write beats go to the SRAM in the same cycle as the W handshake.
    always_comb begin
        ram_en = 1'b0;
        ram_we = 4'b0000;
        if (resetn && state == ST_RD_ISSUE) begin
            ram_en = 1'b1;
        end
        if (w_fire) begin
            ram_en = 1'b1;
            ram_we = wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            prio    <= 1'b0;
            id_q    <= 4'd0;
            base_q  <= '0;
            len_q   <= 2'd0;
            beat    <= 2'd0;
            err     <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (awvalid && awready) begin
                        id_q   <= awid;
                        base_q <= awaddr[ADDR_W+1:2];
                        len_q  <= clamp_len(awlen);
                        err    <= (awlen > 8'd3);
                        beat   <= 2'd0;
                        prio   <= 1'b1;
                        state  <= ST_WR_DATA;
                    end else if (arvalid && arready) begin
                        id_q   <= arid;
                        base_q <= araddr[ADDR_W+1:2];
                        len_q  <= clamp_len(arlen);
                        err    <= (arlen > 8'd3);
                        beat   <= 2'd0;
                        prio   <= 1'b0;
                        state  <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    rdata_q <= ram_rdata;
                    state   <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rready) begin
                        if (beat_last) begin
                            state <= ST_IDLE;
                        end else begin
                            beat  <= beat + 2'd1;
                            state <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (wvalid) begin
                        // wlast arriving early or late is an error; either
                        // one ends the burst.
                        if (wlast != beat_last) begin
                            err <= 1'b1;
                        end
                        if (wlast || beat_last) begin
                            state <= ST_WR_RESP;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave that serves the CPU-side AXI master (arid 0 = inst, 1 = data; awid 1) from a single-port synchronous SRAM.
- One transaction at a time. Single-beat or INCR bursts of up to 4 beats, 32-bit beats.
- Used as the memory model behind the CPU bridge in unit benches, and as an on-chip RAM in the SoC.

Parameters:
- ADDR_W, 16, SRAM word-address width. Byte address bits [ADDR_W+1:2] index the SRAM; higher bits are ignored.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read request (arsize, arburst ignored; always treated as 4-byte INCR)
- arvalid  in  1 ; arready  out  1
- rid/rdata/rresp/rlast  out  4/32/2/1 ; rvalid  out  1 ; rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write request (awsize, awburst ignored)
- awvalid  in  1 ; awready  out  1
- wid/wdata/wstrb/wlast  in  4/32/4/1 ; wvalid  in  1 ; wready  out  1
- bid/bresp  out  4/2 ; bvalid  out  1 ; bready  in  1
- arlock/arcache/arprot, awlock/awcache/awprot  in  2/4/3  ignored
- ram_en  out  1 ; ram_we  out  4 ; ram_addr  out  ADDR_W ; ram_wdata  out  32
- ram_rdata  in  32  valid the cycle after ram_en with ram_we==0

Behaviour:
- Reset: resetn is synchronous, active-low, on clk. While resetn is low:
  - All valid/ready outputs, ram_en and ram_we are 0.
  - The FSM goes to IDLE and prio (last-grant flag) resets to 0.
  - Reset mid-burst abandons the burst; no response is issued.
- FSM states: IDLE, RD_ISSUE, RD_CAP, RD_DATA, WR_DATA, WR_RESP.
- IDLE arbitration:
  - awready = (state==IDLE) & grant_w. arready = (state==IDLE) & grant_r.
  - Only awvalid pending: grant_w. Only arvalid pending: grant_r.
  - Both pending: grant goes to the class not served last (prio); prio flips on each grant.
  - On the handshake, latch id, address word index, len (clamped: len_q = len>3 ? 3 : len) and err = (len>3). Clear beat to 0.
  - Go to RD_ISSUE after AR, WR_DATA after AW.
- Read path:
  - RD_ISSUE: ram_en=1, ram_we=0, ram_addr = base+beat (mod 2^ADDR_W, wraps silently).
  - RD_CAP: rdata_q <= ram_rdata.
  - RD_DATA: rvalid=1, rdata=rdata_q, rid=id_q, rlast = (beat==len_q), rresp = err ? 2'b10 : 2'b00. Outputs are held stable while rready is low.
  - On rvalid&rready: if rlast go to IDLE, else beat++ and go to RD_ISSUE.
  - Timing: AR handshake at cycle T gives first rvalid at T+3; each later beat is 3 cycles after the prior handshake.
- Write path:
  - WR_DATA: wready=1.
  - On wvalid: ram_en=1, ram_we=wstrb, ram_addr=base+beat, ram_wdata=wdata, in the same cycle (combinational from the handshake).
  - The burst ends on (wlast | beat==len_q); otherwise beat++.
  - If wlast and (beat==len_q) disagree, set err. Further W beats are not accepted.
  - wid is ignored.
- WR_RESP: bvalid=1, bid=id_q, bresp = err ? 2'b10 : 2'b00. On bready, go to IDLE.
- Hazards: a write's SRAM update completes before WR_RESP, so a later read always returns new data. No concurrent read/write.
- Zero-strobe write beats still count as beats.

Decomposition:
- Shared package (axi_pkg):
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - BURST_INCR=2'b01, SIZE_4B=3'b010.
  - State encoding constants.
  - MAX_BEATS=4.
- No sub-module is needed. The 2-way round-robin arbiter stays inline (one flop).

Test Plan:
- Single read: preload word 0x40 with 0xDEADBEEF; AR araddr=0x100 arlen=0 arid=1 -> at T+3 rvalid=1, rdata=0xDEADBEEF, rid=1, rlast=1, rresp=0.
- 4-beat write then read: AW awaddr=0x200 awlen=3 awid=1; W 0x11,0x22,0x33,0x44 (strb 4'hF, wlast on 4th) -> bvalid, bid=1, bresp=0. AR arlen=3 arid=0 -> four beats 0x11..0x44, rlast only on 4th.
- Byte strobe: word=0xAABBCCDD, write 0x00000011 with wstrb=4'b0001 -> read returns 0xAABBCC11.
- Backpressure/arbitration: arvalid and awvalid asserted together from reset -> write granted first (prio=0), read second. Hold rready=0 for 5 cycles -> rdata stable, rvalid held.
- Errors: early wlast on beat 1 of awlen=3 -> bresp=2'b10 and only 2 SRAM writes. arlen=7 -> 4 beats, each rresp=2'b10, rlast on 4th.
- Reset mid-burst: assert resetn=0 during RD_DATA of beat 2 -> next cycle rvalid=0, arready=0, ram_en=0. After release, a new single read completes normally.
